// File: rtl/tlul_mem_responder_if.sv
// TileLink-UL A/D channel bundle between an initiator (master) and the memory responder (slave).
interface tlul_mem_responder_if;
  logic         a_ready;
  logic         a_valid;
  logic [2:0]   a_opcode;
  logic [2:0]   a_size;
  logic [8:0]   a_source;
  logic [35:0]  a_address;
  logic [31:0]  a_mask;
  logic [255:0] a_data;

  logic         d_ready;
  logic         d_valid;
  logic [2:0]   d_opcode;
  logic [2:0]   d_size;
  logic [8:0]   d_source;
  logic         d_denied;
  logic [255:0] d_data;
  logic         d_corrupt;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output d_ready,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  d_ready,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tlul_mem_responder.sv
// TL-UL single-beat memory responder backed by a 256-bit register array with an in-order response FIFO.
// Optional random back-pressure on both channels is enabled by defining TLUL_RESP_STALL_EN.
module tlul_mem_responder #(
  parameter logic [35:0] BASE_ADDR  = 36'h0,
  parameter int          MEM_WORDS  = 64,
  parameter int          RESP_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  tlul_mem_responder_if.slave tl
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [36:0] WIN_BYTES = 37'(MEM_WORDS) * 37'd32;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] D_ACK          = 3'd0;
  localparam logic [2:0] D_ACK_DATA     = 3'd1;

  typedef struct packed {
    logic [2:0]   opcode;
    logic [2:0]   size;
    logic [8:0]   source;
    logic         denied;
    logic [255:0] data;
    logic         corrupt;
  } resp_t;

  logic [255:0]     mem [MEM_WORDS];
  resp_t            fifo [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic accept_open;
  logic deliver_open;

`ifdef TLUL_RESP_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16/14/13/11, used only to throttle the two handshakes
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign accept_open  = (lfsr[1:0] != 2'b00);
  assign deliver_open = (lfsr[3:2] != 2'b00);
`else
  assign accept_open  = 1'b1;
  assign deliver_open = 1'b1;
`endif

  logic fire;
  logic pop;
  logic has_entry;

  assign has_entry  = (count != '0);
  assign tl.a_ready = (count < CNT_W'(RESP_DEPTH)) && accept_open;
  assign tl.d_valid = has_entry && deliver_open;
  assign fire       = tl.a_valid && tl.a_ready;
  assign pop        = tl.d_valid && tl.d_ready;

  logic [35:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic [5:0]       align_mask;
  logic             aligned;
  logic             is_put;
  logic             is_get;
  logic             opcode_ok;
  logic             denied;
  resp_t            push_resp;

  assign offset     = tl.a_address - BASE_ADDR;
  assign word_idx   = offset[5 +: IDX_W];
  assign in_range   = (tl.a_address >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign align_mask = 6'((7'd1 << tl.a_size) - 7'd1);
  assign aligned    = ((tl.a_address[5:0] & align_mask) == 6'd0);
  assign is_put     = (tl.a_opcode == OP_PUT_FULL) || (tl.a_opcode == OP_PUT_PARTIAL);
  assign is_get     = (tl.a_opcode == OP_GET);
  assign opcode_ok  = is_put || is_get;
  assign denied     = !opcode_ok || (tl.a_size > 3'd5) || !aligned || !in_range;

  // Illegal opcodes are answered like a denied Get: data-carrying and corrupt
  always_comb begin
    push_resp         = '0;
    push_resp.opcode  = is_put ? D_ACK : D_ACK_DATA;
    push_resp.size    = tl.a_size;
    push_resp.source  = tl.a_source;
    push_resp.denied  = denied;
    push_resp.corrupt = denied && !is_put;
    if (is_get && !denied) begin
      push_resp.data = mem[word_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int w = 0; w < MEM_WORDS; w++) begin
        mem[w] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire && is_put && !denied) begin
        for (int b = 0; b < 32; b++) begin
          if (tl.a_mask[b]) begin
            mem[word_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
          end
        end
      end
      if (fire) begin
        fifo[wr_ptr] <= push_resp;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stale FIFO slots are masked so an empty responder presents all-zero D fields
  resp_t head;
  assign head = has_entry ? fifo[rd_ptr] : '0;

  assign tl.d_opcode  = head.opcode;
  assign tl.d_size    = head.size;
  assign tl.d_source  = head.source;
  assign tl.d_denied  = head.denied;
  assign tl.d_data    = head.data;
  assign tl.d_corrupt = head.corrupt;

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Self-checking bench for tlul_mem_responder: directed scenarios plus randomized traffic against a queue/array model.
module tb_tlul_mem_responder;

  localparam logic [35:0] BASE  = 36'h0_0001_0000;
  localparam int          WORDS = 64;
  localparam int          DEPTH = 4;

  typedef struct {
    logic [2:0]   opcode;
    logic [2:0]   size;
    logic [8:0]   source;
    logic         denied;
    logic [255:0] data;
    logic         corrupt;
  } resp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  tlul_mem_responder_if bus();

  tlul_mem_responder #(
    .BASE_ADDR (BASE),
    .MEM_WORDS (WORDS),
    .RESP_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tl   (bus)
  );

  int assertCount = 0;
  int failCount   = 0;
  int acceptCount = 0;
  int popCount    = 0;

  resp_t        expQ[$];
  logic [255:0] modelMem [WORDS];

  logic [255:0] lastData;
  logic [8:0]   lastSource;
  logic [2:0]   lastOpcode;
  logic         lastDenied;
  logic         lastCorrupt;

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference behaviour: decode by plain address arithmetic and queue the expected response
  task automatic modelAccept();
    resp_t           r;
    longint unsigned addr;
    longint unsigned base;
    bit              isPut;
    bit              legal;
    bit              inRange;
    bit              aligned;
    bit              denied;
    int              idx;
    addr    = 64'(bus.a_address);
    base    = 64'(BASE);
    isPut   = (bus.a_opcode == 3'd0) || (bus.a_opcode == 3'd1);
    legal   = isPut || (bus.a_opcode == 3'd4);
    inRange = (addr >= base) && (addr < base + 64'(WORDS * 32));
    aligned = (bus.a_size <= 3'd5) && ((addr % (64'd1 << bus.a_size)) == 0);
    denied  = !(legal && inRange && aligned);
    r.opcode  = isPut ? 3'd0 : 3'd1;
    r.size    = bus.a_size;
    r.source  = bus.a_source;
    r.denied  = denied;
    r.corrupt = denied && !isPut;
    r.data    = '0;
    if (!denied) begin
      idx = int'((addr - base) / 32);
      if (isPut) begin
        for (int b = 0; b < 32; b++) begin
          if (bus.a_mask[b]) modelMem[idx][8*b +: 8] = bus.a_data[8*b +: 8];
        end
      end else begin
        r.data = modelMem[idx];
      end
    end
    expQ.push_back(r);
  endtask

  always @(negedge clock) begin
    resp_t e;
    if (reset) begin
      expQ.delete();
      for (int w = 0; w < WORDS; w++) modelMem[w] = '0;
    end else begin
      checkOutput("a_ready", bus.a_ready, expQ.size() < DEPTH);
      checkOutput("d_valid", bus.d_valid, expQ.size() != 0);
      if (bus.d_valid && bus.d_ready) begin
        popCount++;
        lastData    = bus.d_data;
        lastSource  = bus.d_source;
        lastOpcode  = bus.d_opcode;
        lastDenied  = bus.d_denied;
        lastCorrupt = bus.d_corrupt;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", bus.d_valid, 1'b0);
        end else begin
          e = expQ.pop_front();
          checkOutput("d_opcode", bus.d_opcode, e.opcode);
          checkOutput("d_size", bus.d_size, e.size);
          checkOutput("d_source", bus.d_source, e.source);
          checkOutput("d_denied", bus.d_denied, e.denied);
          checkOutput("d_corrupt", bus.d_corrupt, e.corrupt);
          checkOutput("d_data", bus.d_data, e.data);
        end
      end
      if (bus.a_valid && bus.a_ready) begin
        acceptCount++;
        modelAccept();
      end
    end
  end

  // Entered and left at posedge+1; holds the request until accepted
  task automatic applyStimulus(input logic [2:0] opcode, input logic [2:0] size, input logic [8:0] source,
                               input logic [35:0] address, input logic [31:0] mask, input logic [255:0] data);
    int waitCycles = 0;
    bus.a_valid   = 1'b1;
    bus.a_opcode  = opcode;
    bus.a_size    = size;
    bus.a_source  = source;
    bus.a_address = address;
    bus.a_mask    = mask;
    bus.a_data    = data;
    @(negedge clock);
    while (!bus.a_ready && waitCycles < 64) begin
      @(posedge clock); #1;
      bus.d_ready = 1'b1;
      waitCycles++;
      @(negedge clock);
    end
    if (!bus.a_ready) checkOutput("accept_timeout", bus.a_ready, 1'b1);
    @(posedge clock); #1;
    bus.a_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.d_ready = 1'b1;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", bus.d_valid, 1'b0);
  endtask

  initial begin
    logic [255:0] pat;
    logic [35:0]  addr;
    logic [2:0]   opc;
    logic [2:0]   sz;
    int           startAcc;
    int           startPop;
    int           lane;
    int           sel;
    int           r;

    bus.a_valid   = 1'b0;
    bus.a_opcode  = '0;
    bus.a_size    = '0;
    bus.a_source  = '0;
    bus.a_address = '0;
    bus.a_mask    = '0;
    bus.a_data    = '0;
    bus.d_ready   = 1'b1;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_a_ready", bus.a_ready, 1'b1);
    checkOutput("reset_d_valid", bus.d_valid, 1'b0);
    checkOutput("reset_d_data", bus.d_data, '0);
    checkOutput("reset_d_source", bus.d_source, '0);
    checkOutput("reset_d_denied", bus.d_denied, 1'b0);
    @(posedge clock); #1;

    $display("[TB] PutFull then Get");
    pat = {8{32'h1234_5678}};
    applyStimulus(3'd0, 3'd5, 9'h1A, BASE + 36'h40, 32'hFFFF_FFFF, pat);
    applyStimulus(3'd4, 3'd5, 9'h1B, BASE + 36'h40, 32'h0, '0);
    drain();
    checkOutput("t1_get_data", lastData, pat);
    checkOutput("t1_get_source", lastSource, 9'h1B);
    checkOutput("t1_get_opcode", lastOpcode, 3'd1);

    $display("[TB] PutPartial merge");
    applyStimulus(3'd0, 3'd5, 9'h02, BASE + 36'h80, 32'hFFFF_FFFF, {32{8'h55}});
    applyStimulus(3'd1, 3'd5, 9'h03, BASE + 36'h80, 32'h0000_000F, 256'hDEAD_BEEF);
    applyStimulus(3'd4, 3'd5, 9'h04, BASE + 36'h80, 32'h0, '0);
    drain();
    checkOutput("t2_partial_data", lastData, {{28{8'h55}}, 32'hDEAD_BEEF});

    $display("[TB] Denied requests");
    applyStimulus(3'd4, 3'd5, 9'h05, BASE + 36'(WORDS * 32), 32'h0, '0);
    drain();
    checkOutput("t3_oor_denied", lastDenied, 1'b1);
    checkOutput("t3_oor_corrupt", lastCorrupt, 1'b1);
    checkOutput("t3_oor_data", lastData, '0);
    applyStimulus(3'd4, 3'd3, 9'h06, BASE + 36'h44, 32'h0, '0);
    drain();
    checkOutput("t3_misaligned_denied", lastDenied, 1'b1);

    $display("[TB] Back-pressure with full FIFO");
    bus.d_ready = 1'b0;
    startAcc = acceptCount;
    for (int s = 0; s < 6; s++) begin
      bus.a_valid   = 1'b1;
      bus.a_opcode  = 3'd4;
      bus.a_size    = 3'd5;
      bus.a_source  = 9'(s);
      bus.a_address = BASE + 36'h40;
      bus.a_mask    = '0;
      bus.a_data    = '0;
      @(posedge clock); #1;
    end
    bus.a_valid = 1'b0;
    checkOutput("t4_accepted", 32'(acceptCount - startAcc), 32'd4);
    checkOutput("t4_a_ready_full", bus.a_ready, 1'b0);
    drain();
    checkOutput("t4_last_source", lastSource, 9'd3);

    $display("[TB] Streaming Gets");
    bus.d_ready = 1'b1;
    startPop = popCount;
    for (int s = 0; s < 10; s++) begin
      applyStimulus(3'd4, 3'd5, 9'(s), BASE + 36'(s * 32), 32'h0, '0);
    end
    drain();
    checkOutput("t5_pops", 32'(popCount - startPop), 32'd10);
    checkOutput("t5_last_source", lastSource, 9'd9);

    $display("[TB] Reset with pending responses");
    applyStimulus(3'd0, 3'd5, 9'h10, BASE + 36'h100, 32'hFFFF_FFFF, pat);
    drain();
    bus.d_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      applyStimulus(3'd4, 3'd5, 9'(s + 32), BASE + 36'h100, 32'h0, '0);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("t6_d_valid", bus.d_valid, 1'b0);
    checkOutput("t6_a_ready", bus.a_ready, 1'b1);
    @(posedge clock); #1;
    applyStimulus(3'd4, 3'd5, 9'h11, BASE + 36'h100, 32'h0, '0);
    drain();
    checkOutput("t6_cleared_data", lastData, '0);

    $display("[TB] Randomized traffic");
    for (int n = 0; n < 300; n++) begin
      bus.d_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clock); #1;
      end else begin
        r = $urandom_range(0, 19);
        if (r < 7)       opc = 3'd0;
        else if (r < 12) opc = 3'd1;
        else if (r < 18) opc = 3'd4;
        else             opc = ($urandom_range(0, 1) == 0) ? 3'(r - 16) : 3'($urandom_range(5, 7));
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        sel = $urandom_range(0, 9);
        if (sel < 8) begin
          lane = $urandom_range(0, 31);
          if ($urandom_range(0, 3) != 0) lane = lane - (lane % (1 << sz));
          addr = BASE + 36'($urandom_range(0, 15) * 32 + lane);
        end else if (sel == 8) begin
          addr = BASE + 36'(WORDS * 32) + 36'($urandom_range(0, 4095));
        end else begin
          addr = BASE - 36'd1 - 36'($urandom_range(0, 4095));
        end
        applyStimulus(opc, sz, 9'($urandom), addr, $urandom, {8{$urandom}});
      end
    end
    drain();
    repeat (2) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/tlul_mem_responder.md
Name: tlul_mem_responder

Overview:
- TileLink-UL responder (slave) model: accepts single-beat Get / PutFullData / PutPartialData on channel A and returns AccessAckData / AccessAck on channel D.
- Backed by a small 256-bit-wide register-array memory.
- Serves as the downstream end for the DPI-driven TL-UL initiator agents (DMA bus and others) in standalone bench configurations where no L3/memory model is present.
- Field widths match the initiator side: source 9, address 36, data 256, mask 32.

Parameters:
- BASE_ADDR, 36'h0, byte base address of the memory window.
- MEM_WORDS, 64, number of 32-byte words; power of two, >= 2.
- RESP_DEPTH, 4, response FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- a_ready  out  1  A-channel ready
- a_valid  in  1  A-channel valid
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_size  in  3  log2 bytes
- a_source  in  9  request tag
- a_address  in  36  byte address
- a_mask  in  32  byte lanes
- a_data  in  256  write data
- d_ready  in  1  D-channel ready
- d_valid  out  1  D-channel valid
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_size  out  3  echo of a_size
- d_source  out  9  echo of a_source
- d_denied  out  1  request rejected
- d_data  out  256  read data
- d_corrupt  out  1  data invalid

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset: all memory words = 0; FIFO emptied (count = 0, pointers = 0).
- Reset outputs: a_ready=1, d_valid=0, all d_* fields = 0.
- A accept: fire = a_valid & a_ready.
- a_ready = (count < RESP_DEPTH). It depends only on the registered count, with no combinational path from d_ready. A full FIFO that is popping in the same cycle still shows a_ready=0.
- Decode:
  - offset = a_address - BASE_ADDR.
  - word index = offset[5 +: log2(MEM_WORDS)].
  - in_range = a_address >= BASE_ADDR and offset < MEM_WORDS*32.
- Deny conditions: opcode not in {0,1,4}; a_size > 5; address not aligned to 2^a_size; !in_range. Any of these -> denied.
- PutFull/PutPartial, not denied: on the fire edge, each byte lane i with a_mask[i]=1 takes a_data[8i+7:8i]. Push {AccessAck, size, source, denied=0, data=0, corrupt=0}.
- Get, not denied: push {AccessAckData, size, source, 0, mem[idx], 0}. Data is read combinationally at fire time. The full 256-bit word is returned regardless of mask.
- Denied request:
  - Memory is not modified.
  - A Get (and any illegal opcode) responds with AccessAckData, denied=1, corrupt=1, data=0.
  - A Put responds with AccessAck, denied=1, corrupt=0.
- Ordering: responses are returned strictly in A-acceptance order (FIFO). A Get accepted after a Put to the same word returns the post-write data.
- D channel:
  - d_valid = (count != 0); d_* are driven from the FIFO head.
  - Pop on d_valid & d_ready.
  - Fields stay stable while d_valid=1 and d_ready=0.
- Latency: A fire at edge N -> d_valid=1 in cycle N+1 if the FIFO was empty. Throughput is 1 request/cycle with d_ready held high.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo RESP_DEPTH.
- Reset asserted mid-operation: pending responses are dropped and memory is cleared; the first cycle after reset deasserts matches the reset values above.

Optional Feature:
- Macro: TLUL_RESP_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - a_ready is additionally forced low in cycles where lfsr[1:0] == 2'b00.
  - d_valid is additionally forced low in cycles where lfsr[3:2] == 2'b00. The FIFO head does not pop in those cycles.
  - Gating never drops or reorders responses.
- When not defined: no LFSR is present, and a_ready and d_valid follow the plain rules above.

Test Plan:
- PutFull, address BASE_ADDR+0x40, size 5, mask all-ones, data 256'h1234..., source 9'h1A; then Get at the same address, source 9'h1B. Required: AccessAck with source 1A, denied=0; then AccessAckData with source 1B, data == written value.
- PutPartial, mask 32'h0000_000F, data bytes 0-3 = DEADBEEF, into a word previously all 0x55. Required: a Get returns bytes 0-3 = EF BE AD DE and bytes 4-31 = 0x55.
- Get at BASE_ADDR + MEM_WORDS*32. Required: AccessAckData, denied=1, corrupt=1, data=0. Also a Get with size 3 at an address with addr[2:0]=3'b100. Required: denied=1 (misaligned).
- Hold d_ready=0 and issue 6 back-to-back Gets with RESP_DEPTH=4. Required: exactly 4 accepted, a_ready=0 from the cycle after the 4th fire. Then raise d_ready: responses arrive in source order 0,1,2,3, and a_ready returns to 1 the cycle after the first pop.
- With d_ready=1, stream 10 Gets, one per cycle, sources 0-9. Required: d_valid is continuously high from cycle N+1, and d_source increments 0-9 with no gaps.
- Assert reset for 1 cycle while 3 responses are pending. Required: d_valid=0 and a_ready=1 next cycle. A Get to the previously written word returns 0.
